// File: rtl/sample_packetizer.sv
// Sample packetizer: collects N_SAMPLES 16-bit samples into a register buffer,
// then emits a byte frame (SYNC, SEQ, payload MSB-first, checksum) toward a
// UART transmit FIFO, stalling whenever the FIFO reports full.
module sample_packetizer #(
  parameter int         N_SAMPLES = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  input  logic        fifo_full_i,
  output logic [7:0]  data_o,
  output logic        wr_en_o,
  output logic        busy_o
);

  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int BW = $clog2(2 * N_SAMPLES);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N_SAMPLES - 1);
  localparam logic [BW-1:0] LAST_BYTE   = BW'(2 * N_SAMPLES - 1);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    SYNC    = 3'd1,
    SEQ     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4
  } state_t;

  // Mod-256 running checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic [15:0]    sample_buf_r [N_SAMPLES];
  logic [CW-1:0]  sample_cnt_r;
  logic [BW-1:0]  byte_idx_r;
  logic [7:0]     csum_r;
  logic [7:0]     seq_r;
  logic [CW-1:0]  payload_sel_s;
  logic [15:0]    cur_sample_s;
  logic [7:0]     payload_byte_s;
  logic           accept_s;

  assign accept_s      = (state_r == COLLECT) && sample_valid_i;
  assign payload_sel_s = CW'(byte_idx_r >> 1);
  assign cur_sample_s  = sample_buf_r[payload_sel_s];

  // Select the MSB or LSB byte of the current payload sample.
  always_comb begin
    payload_byte_s = 8'h00;
    if (byte_idx_r[0]) begin
      payload_byte_s = cur_sample_s[7:0];
    end else begin
      payload_byte_s = cur_sample_s[15:8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; byte states advance only on a real write.
  always_comb begin
    next_state_s   = state_r;
    sample_ready_o = 1'b0;
    wr_en_o        = 1'b0;
    busy_o         = 1'b1;
    data_o         = 8'h00;
    case (state_r)
      COLLECT: begin
        sample_ready_o = 1'b1;
        busy_o         = 1'b0;
        if (sample_valid_i && (sample_cnt_r == LAST_SAMPLE)) begin
          next_state_s = SYNC;
        end else begin
          next_state_s = COLLECT;
        end
      end
      SYNC: begin
        data_o  = SYNC_BYTE;
        wr_en_o = !fifo_full_i;
        if (!fifo_full_i) begin
          next_state_s = SEQ;
        end else begin
          next_state_s = SYNC;
        end
      end
      SEQ: begin
        data_o  = seq_r;
        wr_en_o = !fifo_full_i;
        if (!fifo_full_i) begin
          next_state_s = PAYLOAD;
        end else begin
          next_state_s = SEQ;
        end
      end
      PAYLOAD: begin
        data_o  = payload_byte_s;
        wr_en_o = !fifo_full_i;
        if (!fifo_full_i && (byte_idx_r == LAST_BYTE)) begin
          next_state_s = CSUM;
        end else begin
          next_state_s = PAYLOAD;
        end
      end
      CSUM: begin
        data_o  = csum_r;
        wr_en_o = !fifo_full_i;
        if (!fifo_full_i) begin
          next_state_s = COLLECT;
        end else begin
          next_state_s = CSUM;
        end
      end
      default: begin
        next_state_s = COLLECT;
      end
    endcase
  end

  // Sample capture into the buffer and sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_r <= {CW{1'b0}};
      for (int i = 0; i < N_SAMPLES; i++) begin
        sample_buf_r[i] <= 16'h0000;
      end
    end else if (accept_s) begin
      sample_buf_r[sample_cnt_r] <= sample_i;
      if (sample_cnt_r == LAST_SAMPLE) begin
        sample_cnt_r <= {CW{1'b0}};
      end else begin
        sample_cnt_r <= sample_cnt_r + CW'(1);
      end
    end
  end

  // Payload byte index, stepped on each written payload byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_r <= {BW{1'b0}};
    end else if ((state_r == PAYLOAD) && wr_en_o) begin
      if (byte_idx_r == LAST_BYTE) begin
        byte_idx_r <= {BW{1'b0}};
      end else begin
        byte_idx_r <= byte_idx_r + BW'(1);
      end
    end
  end

  // Checksum accumulation over SEQ and payload; sequence bump at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_r <= 8'h00;
      seq_r  <= 8'h00;
    end else if (wr_en_o) begin
      if ((state_r == SEQ) || (state_r == PAYLOAD)) begin
        csum_r <= csum_add(csum_r, data_o);
      end else if (state_r == CSUM) begin
        csum_r <= 8'h00;
        seq_r  <= seq_r + 8'h01;
      end
    end
  end

endmodule

// File: doc/sample_packetizer.md
SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, giving the number of 16-bit samples per frame (legal range 1..64).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port sample_i, input, 16 bits: sample data.
REQ-006 SHALL have port sample_valid_i, input, 1 bit: sample_i is valid.
REQ-007 SHALL have port sample_ready_o, output, 1 bit: block accepts a sample this cycle.
REQ-008 SHALL have port fifo_full_i, input, 1 bit: the downstream UART transmit FIFO is full.
REQ-009 SHALL have port data_o, output, 8 bits: byte to the UART transmit path.
REQ-010 SHALL have port wr_en_o, output, 1 bit: write strobe for data_o, one byte per cycle high.
REQ-011 SHALL have port busy_o, output, 1 bit: a frame is being emitted.

Function
REQ-012 SHALL implement FSM states COLLECT, SYNC, SEQ, PAYLOAD, CSUM.
REQ-013 SHALL, in COLLECT, drive sample_ready_o=1; a sample transfers when sample_valid_i && sample_ready_o at a clock edge.
REQ-014 SHALL store accepted samples in an N_SAMPLES-entry register buffer indexed by a sample counter, with the first accepted sample at index 0.
REQ-015 SHALL, on the edge that accepts sample N_SAMPLES-1, transition to SYNC and clear the sample counter.
REQ-016 SHALL drive sample_ready_o=0 in every state other than COLLECT; no sample is accepted or dropped while a frame is emitted.
REQ-017 SHALL drive data_o and wr_en_o combinationally: wr_en_o = (state in SYNC/SEQ/PAYLOAD/CSUM) && !fifo_full_i.
REQ-018 SHALL advance the byte state only on an edge where wr_en_o=1; while fifo_full_i=1, the state and data_o SHALL hold.
REQ-019 SHALL drive data_o as follows in the emitting states:
- SYNC: SYNC_BYTE.
- SEQ: the 8-bit frame sequence counter.
- PAYLOAD: buffered samples, index 0 first, MSB byte then LSB byte.
- CSUM: checksum.
REQ-020 SHALL step PAYLOAD through 2*N_SAMPLES bytes using a byte index, then go to CSUM.
REQ-021 SHALL compute the checksum as the mod-256 sum of the SEQ byte and all payload bytes, excluding SYNC, accumulated as each byte is written.
REQ-022 SHALL, on the edge writing CSUM, increment the sequence counter (wrapping 8'hFF->8'h00), clear the checksum accumulator, and return to COLLECT.
REQ-023 SHALL emit exactly 3+2*N_SAMPLES bytes per frame, and SHALL never assert wr_en_o while fifo_full_i=1.
REQ-024 SHALL drive busy_o=1 in every state except COLLECT.
REQ-025 SHALL start the first frame after reset with sequence 8'h00.
REQ-026 SHALL have minimum frame latency: SYNC byte written on the cycle after the last sample is accepted, then one byte per cycle while fifo_full_i=0.

Reset
REQ-027 SHALL, while rst=0 (asynchronously), force:
- state=COLLECT
- sample counter=0, byte index=0, checksum=0, sequence=0
- sample_ready_o=1, wr_en_o=0, busy_o=0, data_o=8'h00
REQ-028 SHALL, on reset asserted mid-frame, abandon the partial frame and discard buffered samples; after release, the next frame starts with SYNC and sequence 8'h00.

Verification
REQ-029 SHALL pass this scenario: N_SAMPLES=4, fifo_full_i=0, samples 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 -> bytes A5 00 12 34 56 78 9A BC DE F0 38 on 11 consecutive cycles.
REQ-030 SHALL pass this scenario: repeat the same samples as a second frame -> SEQ byte 01, checksum 39.
REQ-031 SHALL pass this scenario: fifo_full_i held 1 for 5 cycles while in PAYLOAD at byte 56 -> wr_en_o=0 and data_o=56 for those 5 cycles, then 78 follows; the frame is otherwise unchanged.
REQ-032 SHALL pass this scenario: sample_valid_i held 1 during emission -> sample_ready_o=0 throughout, and the held sample is accepted on the first COLLECT cycle.
REQ-033 SHALL pass this scenario: 256 frames -> SEQ bytes run 00..FF, and the 257th frame's SEQ byte is 00.
REQ-034 SHALL pass this scenario: rst pulsed low after the 3rd payload byte -> outputs reach their reset values immediately, and the next full frame begins A5 00.
